pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 128: width of the datapath payload (pc, operands, immediate); held through flush.
REQ-002 Parameter CTRL_W, default 32: width of the control payload (register indices, enables, ALU/branch selects); cleared on flush.
REQ-003 Parameter CTRL_RST, default 0: CTRL_W-bit value loaded into ctrl_out on reset and flush (bubble encoding).
REQ-004 Parameter CNT_W, default 16: stall performance counter width.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  kill all held entries; insert bubble.
REQ-008 stall  input  1  freeze stage: no enqueue, no dequeue, no flush.
REQ-009 in_valid  input  1  upstream entry present.
REQ-010 in_ready  output  1  stage accepts entry this cycle.
REQ-011 in_data  input  DATA_W  upstream datapath payload.
REQ-012 in_ctrl  input  CTRL_W  upstream control payload.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  downstream consumes head this cycle.
REQ-015 out_data  output  DATA_W  head datapath payload.
REQ-016 out_ctrl  output  CTRL_W  head control payload; CTRL_RST when out_valid=0.
REQ-017 occupancy  output  2  entries held (0..2).
REQ-018 stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-019 Enqueue occurs on a rising edge when in_valid && in_ready && !stall && !flush; dequeue when out_valid && out_ready && !stall && !flush.
REQ-020 Entries leave in arrival order; latency in->out is exactly one cycle when empty.
REQ-021 State machine EMPTY(occ 0), ONE(occ 1), TWO(occ 2): EMPTY->ONE on enq; ONE->ONE on enq+deq; ONE->TWO on enq without deq; ONE->EMPTY on deq without enq; TWO->ONE on deq (no enq possible in TWO).
REQ-022 Simultaneous enq+deq in ONE: new entry becomes head next cycle, occupancy unchanged.
REQ-023 flush (stall=0): next state EMPTY, out_valid=0, out_ctrl=CTRL_RST, out_data holds its previous value, in-cycle input discarded.
REQ-024 stall=1: all state, outputs and stall_cnt held, in_ready=0, flush ignored that cycle.
REQ-025 stall_cnt increments by 1 each cycle with out_valid && !out_ready && !stall, saturates at all-ones, not cleared by flush.
REQ-026 out_valid = (occupancy != 0); out_ctrl/out_data driven from head register only, no combinational path from in_* to out_*.

Reset
REQ-027 On rst_n low, asynchronously: state EMPTY, occupancy 0, out_valid 0, out_ctrl CTRL_RST, out_data 0, stall_cnt 0, in_ready 0 while rst_n low.
REQ-028 Reset asserted mid-transfer discards all entries; first enqueue possible on the first edge after rst_n rises.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: two-entry skid; in_ready = (state != TWO) && !stall, registered-state only, no dependence on out_ready; TWO reachable.
REQ-030 PIPE_STAGE_SKID_EN undefined: single entry; in_ready = (!out_valid || out_ready) && !stall (combinational); TWO unreachable; occupancy never exceeds 1.

Structure
REQ-031 Shared package pipe_pkg holds the state enum (PS_EMPTY, PS_ONE, PS_TWO) and the default bubble constant.
REQ-032 One sub-module pipe_slot (DATA_W+CTRL_W register with load enable and ctrl-only clear) instantiated for head and, with the macro, skid slot.

Verification
REQ-033 Empty, in_valid=1, in_ctrl=0x0000_00A5, out_ready=1 -> next cycle out_valid=1, out_ctrl=0xA5, occupancy=1.
REQ-034 SKID_EN, out_ready=0, enqueue 0x11 then 0x22 -> occupancy=2, in_ready=0, stall_cnt=1 then 2; out_ready=1 -> out 0x11 then 0x22 in order.
REQ-035 occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=CTRL_RST, out_data unchanged.
REQ-036 stall=1 and flush=1 together for 3 cycles with occupancy=1 -> all outputs unchanged, in_ready=0, stall_cnt unchanged.
REQ-037 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
REQ-038 rst_n low mid-transfer with occupancy=2 -> immediately occupancy=0, out_valid=0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types and constants for the pipe_stage_buffer pipeline register slice.
// Holds the occupancy state encoding and the default bubble (control) value.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_e;

    // Bubble encoding loaded into the control payload on reset and flush.
    localparam logic [31:0] PS_BUBBLE = 32'h0000_0000;

    function automatic logic [1:0] ps_occupancy(input ps_state_e st);
        logic [1:0] occ;
        case (st)
            PS_ONE:  occ = 2'd1;
            PS_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_slot.sv
// One pipeline entry: datapath + control register with load enable.
// clr resets only the control field (bubble); the datapath field holds its value.
module pipe_slot #(
    parameter int unsigned          DATA_W   = 128,
    parameter int unsigned          CTRL_W   = 32,
    parameter logic [CTRL_W-1:0]    CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic              clr,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (clr) begin
            ctrl_d = CTRL_RST;
        end
        if (ld) begin
            data_d = d_data;
            ctrl_d = d_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= CTRL_RST;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign q_data = data_q;
    assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer with flush/stall, bubble insertion and a stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer; otherwise single entry.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = 128,
    parameter int unsigned       CTRL_W   = 32,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(PS_BUBBLE),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    ps_state_e         state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              enq, deq, flush_eff;
    logic              head_ld, head_clr;
    logic [DATA_W-1:0] head_d_data, head_q_data;
    logic [CTRL_W-1:0] head_d_ctrl, head_q_ctrl;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_ld, skid_clr;
    logic [DATA_W-1:0] skid_q_data;
    logic [CTRL_W-1:0] skid_q_ctrl;
`endif

    assign out_valid = (state_q != PS_EMPTY);
    assign occupancy = ps_occupancy(state_q);
    assign out_data  = head_q_data;
    assign out_ctrl  = head_q_ctrl;
    assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = rst_n && (state_q != PS_TWO) && !stall;
`else
    assign in_ready = rst_n && (!out_valid || out_ready) && !stall;
`endif

    assign flush_eff = flush && !stall;
    assign enq       = in_valid && in_ready && !stall && !flush;
    assign deq       = out_valid && out_ready && !stall && !flush;

    always_comb begin
        state_d     = state_q;
        head_ld     = 1'b0;
        head_clr    = 1'b0;
        head_d_data = in_data;
        head_d_ctrl = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
        skid_ld     = 1'b0;
        skid_clr    = 1'b0;
`endif
        if (flush_eff) begin
            state_d  = PS_EMPTY;
            head_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clr = 1'b1;
`endif
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (enq) begin
                        head_ld = 1'b1;
                        state_d = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (enq && deq) begin
                        head_ld = 1'b1;
                    end else if (deq) begin
                        head_clr = 1'b1;
                        state_d  = PS_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (enq) begin
                        skid_ld = 1'b1;
                        state_d = PS_TWO;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PS_TWO: begin
                    // Skid entry is promoted to head; in_ready is low so no enqueue here.
                    if (deq) begin
                        head_ld     = 1'b1;
                        head_d_data = skid_q_data;
                        head_d_ctrl = skid_q_ctrl;
                        state_d     = PS_ONE;
                    end
                end
`endif
                default: begin
                    state_d  = PS_EMPTY;
                    head_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PS_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_RST(CTRL_RST)
    ) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (head_ld),
        .clr   (head_clr),
        .d_data(head_d_data),
        .d_ctrl(head_d_ctrl),
        .q_data(head_q_data),
        .q_ctrl(head_q_ctrl)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_RST(CTRL_RST)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (skid_ld),
        .clr   (skid_clr),
        .d_data(in_data),
        .d_ctrl(in_ctrl),
        .q_data(skid_q_data),
        .q_ctrl(skid_q_ctrl)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed, table-driven bench for pipe_stage_buffer (both PIPE_STAGE_SKID_EN builds).
// Table rows: inputs, in_ready before the edge, and outputs after the edge.
module tb_pipe_stage_buffer;

    localparam int unsigned       DW   = 16;
    localparam int unsigned       CW   = 32;
    localparam logic [CW-1:0]     CRST = 32'hDEAD_0000;
    localparam int unsigned       CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush, stall, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]   in_data, out_data;
    logic [CW-1:0]   in_ctrl, out_ctrl;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic            st, fl, iv;
        logic [DW-1:0]   idata;
        logic [CW-1:0]   ictrl;
        logic            ordy;
        logic            e_rdy, e_ov;
        logic [CW-1:0]   e_ctrl;
        logic [DW-1:0]   e_data;
        logic [1:0]      e_occ;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_buffer #(
        .DATA_W  (DW),
        .CTRL_W  (CW),
        .CTRL_RST(CRST),
        .CNT_W   (CNTW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .stall    (stall),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, fl, iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, e_rdy, e_ov, input logic [CW-1:0] e_ctrl,
                       input logic [DW-1:0] e_data, input logic [1:0] e_occ,
                       input logic [CNTW-1:0] e_cnt);
        vec_t v;
        v.st = st; v.fl = fl; v.iv = iv; v.idata = d; v.ictrl = c; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ctrl = e_ctrl; v.e_data = e_data;
        v.e_occ = e_occ; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input logic [1:0] occ,
                            input logic [CNTW-1:0] cnt);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_ctrl"},  32'(out_ctrl),  32'(c));
        chk({tag, ".out_data"},  32'(out_data),  32'(d));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
    endtask

    task automatic drive(input logic st, fl, iv, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic ordy);
        stall = st; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    endtask

    logic [CNTW-1:0] exp_cnt;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 1, 16'hFFFF, 32'hFFFF_FFFF, 1);
        #12;
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        chk_outs("reset", 0, CRST, 16'h0, 2'd0, 4'd0);

`ifdef PIPE_STAGE_SKID_EN
        //  st fl iv data      ctrl          ordy rdy ov  e_ctrl        e_data    occ cnt
        add(0, 0, 1, 16'h1111, 32'h0000_00A5, 1,  1,  1,  32'h0000_00A5, 16'h1111, 1, 0);
        add(0, 0, 0, 16'h0000, 32'h0000_0000, 1,  1,  0,  CRST,          16'h1111, 0, 0);
        add(0, 0, 1, 16'h0011, 32'h0000_0011, 0,  1,  1,  32'h0000_0011, 16'h0011, 1, 0);
        add(0, 0, 1, 16'h0022, 32'h0000_0022, 0,  1,  1,  32'h0000_0011, 16'h0011, 2, 1);
        add(0, 0, 1, 16'h0033, 32'h0000_0033, 0,  0,  1,  32'h0000_0011, 16'h0011, 2, 2);
        add(0, 0, 0, 16'h0000, 32'h0000_0000, 1,  0,  1,  32'h0000_0022, 16'h0022, 1, 2);
        add(0, 0, 1, 16'h0044, 32'h0000_0044, 1,  1,  1,  32'h0000_0044, 16'h0044, 1, 2);
        add(0, 0, 1, 16'h0055, 32'h0000_0055, 0,  1,  1,  32'h0000_0044, 16'h0044, 2, 3);
        add(1, 1, 1, 16'h0F0F, 32'h0000_0F0F, 0,  0,  1,  32'h0000_0044, 16'h0044, 2, 3);
        add(1, 1, 1, 16'h0F0F, 32'h0000_0F0F, 1,  0,  1,  32'h0000_0044, 16'h0044, 2, 3);
        add(1, 1, 0, 16'h0F0F, 32'h0000_0F0F, 0,  0,  1,  32'h0000_0044, 16'h0044, 2, 3);
        add(0, 1, 1, 16'h0066, 32'h0000_0066, 0,  0,  0,  CRST,          16'h0044, 0, 4);
        add(0, 0, 1, 16'h0077, 32'h0000_0077, 1,  1,  1,  32'h0000_0077, 16'h0077, 1, 4);
        add(0, 0, 1, 16'h0088, 32'h0000_0088, 0,  1,  1,  32'h0000_0077, 16'h0077, 2, 5);
        add(0, 0, 0, 16'h0000, 32'h0000_0000, 1,  0,  1,  32'h0000_0088, 16'h0088, 1, 5);
        add(0, 0, 0, 16'h0000, 32'h0000_0000, 1,  1,  0,  CRST,          16'h0088, 0, 5);
        add(0, 1, 1, 16'h0BAD, 32'h0000_0BAD, 1,  1,  0,  CRST,          16'h0088, 0, 5);
        add(0, 0, 1, 16'h0099, 32'h0000_0099, 0,  1,  1,  32'h0000_0099, 16'h0099, 1, 5);
        add(0, 0, 1, 16'h00AA, 32'h0000_00AA, 0,  1,  1,  32'h0000_0099, 16'h0099, 2, 6);
        exp_cnt = 4'd6;
`else
        //  st fl iv data      ctrl          ordy rdy ov  e_ctrl        e_data    occ cnt
        add(0, 0, 1, 16'h1111, 32'h0000_00A5, 1,  1,  1,  32'h0000_00A5, 16'h1111, 1, 0);
        add(0, 0, 1, 16'h2222, 32'h0000_00B6, 1,  1,  1,  32'h0000_00B6, 16'h2222, 1, 0);
        add(0, 0, 1, 16'h3333, 32'h0000_00C7, 0,  0,  1,  32'h0000_00B6, 16'h2222, 1, 1);
        add(0, 0, 0, 16'h0000, 32'h0000_0000, 0,  0,  1,  32'h0000_00B6, 16'h2222, 1, 2);
        add(0, 0, 0, 16'h0000, 32'h0000_0000, 1,  1,  0,  CRST,          16'h2222, 0, 2);
        add(0, 0, 1, 16'h4444, 32'h0000_00D8, 0,  1,  1,  32'h0000_00D8, 16'h4444, 1, 2);
        add(1, 1, 1, 16'h5555, 32'h0000_0055, 1,  0,  1,  32'h0000_00D8, 16'h4444, 1, 2);
        add(1, 1, 1, 16'h5555, 32'h0000_0055, 0,  0,  1,  32'h0000_00D8, 16'h4444, 1, 2);
        add(1, 1, 0, 16'h5555, 32'h0000_0055, 0,  0,  1,  32'h0000_00D8, 16'h4444, 1, 2);
        add(0, 1, 1, 16'h6666, 32'h0000_00E9, 0,  0,  0,  CRST,          16'h4444, 0, 3);
        add(0, 1, 1, 16'h7777, 32'h0000_00F0, 1,  1,  0,  CRST,          16'h4444, 0, 3);
        add(0, 0, 1, 16'h7777, 32'h0000_00F0, 0,  1,  1,  32'h0000_00F0, 16'h7777, 1, 3);
        exp_cnt = 4'd3;
`endif

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].fl, vecs[i].iv, vecs[i].idata, vecs[i].ictrl, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_ctrl, vecs[i].e_data,
                     vecs[i].e_occ, vecs[i].e_cnt);
        end

        // Backpressure held for 20 cycles: counter climbs to 15 and stays there.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 16'h0, 32'h0, 0);
            @(posedge clk);
            #1;
            exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
            chk($sformatf("sat%0d.stall_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
        end
        chk("sat.final", 32'(stall_cnt), 32'd15);

        // Asynchronous reset in mid-cycle with entries held.
        @(negedge clk);
        drive(0, 0, 1, 16'h0C0C, 32'h0000_0C0C, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.in_ready", 32'(in_ready), 32'd0);
        chk_outs("areset", 0, CRST, 16'h0, 2'd0, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 16'h0BBB, 32'h0000_0012, 1);
        #1;
        chk("post_reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_outs("post_reset", 1, 32'h0000_0012, 16'h0BBB, 2'd1, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
